lifo_stack: RTL and testbench
=============================

Name: lifo_stack

Overview:
Parametrised LIFO stack; next generation of the 8-bit/256-entry push/pop stack.
- Generalised in data width, depth and almost-full threshold.
- Adds zero-latency top-of-stack peek, a replace (push+pop) operation, synchronous flush, full/empty/almost-full/count status, and sticky overflow/underflow error flags.
- Sits beside the CPU datapath as call/return and operand stack.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 256, number of entries (>=2, any integer, not required to be a power of 2).
- AFULL, DEPTH-2, almost_full asserted when count >= AFULL.
- Derived (localparam, not overridable): CW = clog2(DEPTH+1), the count width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- push  in  1  push din this cycle.
- pop  in  1  pop top this cycle.
- flush  in  1  synchronous clear of stack contents (count to 0).
- err_clr  in  1  clear sticky error flags.
- din  in  WIDTH  data to push.
- dout  out  WIDTH  current top of stack, combinational from state; 0 when empty.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL.
- count  out  CW  number of valid entries.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop was dropped.

Behaviour:
- State: storage array mem[0..DEPTH-1] (not reset) plus registered sp (CW bits) and the two sticky flags.
- Reset (rst=0, async): sp=0, overflow=0, underflow=0. Outputs: dout=0, empty=1, full=0, count=0, almost_full=(AFULL==0).
- Status outputs are combinational from sp.
- dout = mem[sp-1] when sp>0, else 0. Zero-latency peek: the value popped in a cycle is dout during that cycle.
- Per-cycle operation, resolved in this priority order:
  - flush=1: sp<=0. push/pop ignored; no errors raised.
  - push & !pop & !full: mem[sp]<=din; sp<=sp+1.
  - push & !pop & full: no change; overflow<=1.
  - pop & !push & !empty: sp<=sp-1.
  - pop & !push & empty: no change; underflow<=1.
  - push & pop & !empty (replace, legal even when full): mem[sp-1]<=din; sp unchanged.
  - push & pop & empty: push performed (mem[0]<=din, sp<=1); underflow<=1.
  - neither: hold.
- Write latency: data pushed at edge N appears on dout after edge N (same cycle as the updated count).
- err_clr clears both sticky flags at the edge. If a new error event occurs in the same cycle, the set wins.
- No wrap-around: sp is saturating-guarded by the full/empty checks and never exceeds DEPTH or goes below 0.
- Reset mid-operation: takes effect immediately. Storage contents are undefined after reset but invisible, because dout is gated when empty.
- Reset release: synchronise externally; the block assumes deassertion is clean relative to clk.

Decomposition:
- Package stack_pkg:
  - enum stack_op_e {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE, OP_FLUSH}, used for op decode.
  - Function clog2w for count-width computation.
- Sub-module lifo_stack_mem (parameters WIDTH, DEPTH): register array with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- The top level holds the decode, sp, flags and status logic.

Test Plan:
- Use DEPTH=4, AFULL=3, WIDTH=8 unless noted.
- Reset, then push 0x11, 0x22, 0x33 -> count=3, almost_full=1, full=0, dout=0x33; pop twice -> dout=0x11, count=1.
- Fill to 4 (0xA0..0xA3), then push 0xFF alone -> full=1, count stays 4, dout=0xA3, overflow=1. Pulse err_clr -> overflow=0.
- From empty, pop -> underflow=1, count=0, dout=0. Then push & pop with din=0x5A -> count=1, dout=0x5A, underflow remains 1.
- With full stack (top 0xA3), push & pop with din=0x77 -> count=4, dout=0x77, no flags. Pop -> dout=0xA2.
- Push 3 entries, then assert flush together with push 0x99 -> count=0, empty=1, dout=0, no error flags.
- Mid-stream reset: push 2 entries, drop rst low between edges -> count=0, empty=1, dout=0, flags=0 immediately. Same sequence with push & err_clr while overflowing -> overflow=1 (set wins).

Source files
------------

// File: rtl/lifo_stack_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
// Holds the per-cycle operation encoding and the count/address width function.
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_REPLACE = 3'd3,
    OP_FLUSH   = 3'd4
  } stack_op_e;

  // Bits needed to index n distinct values (minimum 1).
  function automatic int clog2w(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// Register-array storage for the stack: one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module lifo_stack_mem
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int AW   = clog2w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Guard addresses beyond DEPTH when DEPTH is not a power of two.
  assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : {WIDTH{1'b0}};

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with zero-latency peek, replace, flush, status and
// sticky overflow/underflow flags. Storage lives in lifo_stack_mem.
module lifo_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AFULL = DEPTH - 2,
  localparam int CW   = clog2w(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = clog2w(DEPTH);

  stack_op_e        op_s;
  logic [CW-1:0]    sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             we_s;
  logic [AW-1:0]    waddr_s;
  logic [AW-1:0]    raddr_s;
  logic [WIDTH-1:0] rdata_s;

  lifo_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (din),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  assign empty       = (sp_q == {CW{1'b0}});
  assign full        = (int'(sp_q) == DEPTH);
  assign almost_full = (int'(sp_q) >= AFULL);
  assign count       = sp_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign raddr_s     = AW'(sp_q - CW'(1));
  assign dout        = empty ? {WIDTH{1'b0}} : rdata_s;

  // Decode the request into a single operation; flush dominates.
  always_comb begin
    op_s = OP_NOP;
    if (flush) begin
      op_s = OP_FLUSH;
    end else if (push && pop) begin
      op_s = OP_REPLACE;
    end else if (push) begin
      op_s = OP_PUSH;
    end else if (pop) begin
      op_s = OP_POP;
    end else begin
      op_s = OP_NOP;
    end
  end

  // Next stack pointer, write request and sticky flags; a new error beats err_clr.
  always_comb begin
    sp_d    = sp_q;
    ovf_d   = ovf_q & ~err_clr;
    unf_d   = unf_q & ~err_clr;
    we_s    = 1'b0;
    waddr_s = AW'(sp_q);
    case (op_s)
      OP_FLUSH: begin
        sp_d = {CW{1'b0}};
      end
      OP_PUSH: begin
        if (!full) begin
          we_s    = 1'b1;
          waddr_s = AW'(sp_q);
          sp_d    = sp_q + CW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty) begin
          sp_d = sp_q - CW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
      OP_REPLACE: begin
        we_s = 1'b1;
        if (!empty) begin
          waddr_s = AW'(sp_q - CW'(1));
        end else begin
          // Nothing to pop: the push still lands in slot 0.
          waddr_s = {AW{1'b0}};
          sp_d    = CW'(1);
          unf_d   = 1'b1;
        end
      end
      default: begin
        sp_d = sp_q;
      end
    endcase
  end

  // Pointer and error-flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q  <= {CW{1'b0}};
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack (WIDTH=8, DEPTH=4, AFULL=3): directed
// scenarios plus randomized traffic against a queue-based reference model.
module tb_lifo_stack;
  import stack_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push = 1'b0, pop = 1'b0, flush = 1'b0, err_clr = 1'b0;
  logic [W-1:0]  din = 8'h00;
  logic [W-1:0]  dout;
  logic          empty, full, almost_full, overflow, underflow;
  logic [CW-1:0] count;
  logic [15:0]   obs;
  logic [15:0]   exp_v;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] q[$];
  bit m_ovf, m_unf;

  lifo_stack #(.WIDTH(W), .DEPTH(D), .AFULL(AF)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
    .err_clr(err_clr), .din(din), .dout(dout), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  assign obs = {dout, count, empty, full, almost_full, overflow, underflow};

  function automatic logic [15:0] pk(input logic [7:0] d, input int c,
                                     input bit e, f, a, o, u);
    return {d, 3'(c), e, f, a, o, u};
  endfunction

  function automatic logic [15:0] model_vec();
    logic [7:0] top;
    top = (q.size() > 0) ? q[$] : 8'h00;
    return pk(top, q.size(), q.size() == 0, q.size() == D, q.size() >= AF,
              m_ovf, m_unf);
  endfunction

  // One clock with the given inputs; the reference model follows the stack rules.
  task automatic step(input bit pu, po, fl, ec, input logic [7:0] d);
    bit so, su;
    push = pu; pop = po; flush = fl; err_clr = ec; din = d;
    @(posedge clk);
    so = 1'b0; su = 1'b0;
    if (fl) begin
      q.delete();
    end else if (pu && po) begin
      if (q.size() == 0) begin
        q.push_back(d);
        su = 1'b1;
      end else begin
        q[q.size()-1] = d;
      end
    end else if (pu) begin
      if (q.size() == D) so = 1'b1;
      else q.push_back(d);
    end else if (po) begin
      if (q.size() == 0) su = 1'b1;
      else void'(q.pop_back());
    end
    m_ovf = so | (m_ovf & ~ec);
    m_unf = su | (m_unf & ~ec);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; exp_v = pk(8'h00, 0, 1, 0, 0, 0, 0);
    if (obs !== exp_v) begin n_err++; $display("FAIL reset: got %h want %h", obs, exp_v); end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_push_pop();
    step(1, 0, 0, 0, 8'h11);
    step(1, 0, 0, 0, 8'h22);
    step(1, 0, 0, 0, 8'h33);
    n_cmp++; exp_v = pk(8'h33, 3, 0, 0, 1, 0, 0);
    if (obs !== exp_v) begin n_err++; $display("FAIL push3: got %h want %h", obs, exp_v); end
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    n_cmp++; exp_v = pk(8'h11, 1, 0, 0, 0, 0, 0);
    if (obs !== exp_v) begin n_err++; $display("FAIL pop2: got %h want %h", obs, exp_v); end
    step(0, 1, 0, 0, 8'h00);
    n_cmp++; exp_v = pk(8'h00, 0, 1, 0, 0, 0, 0);
    if (obs !== exp_v) begin n_err++; $display("FAIL pop_to_empty: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'hA0 + 8'(i));
    n_cmp++; exp_v = pk(8'hA3, 4, 0, 1, 1, 0, 0);
    if (obs !== exp_v) begin n_err++; $display("FAIL fill4: got %h want %h", obs, exp_v); end
    step(1, 0, 0, 0, 8'hFF);
    n_cmp++; exp_v = pk(8'hA3, 4, 0, 1, 1, 1, 0);
    if (obs !== exp_v) begin n_err++; $display("FAIL overflow: got %h want %h", obs, exp_v); end
    step(0, 0, 0, 1, 8'h00);
    n_cmp++; exp_v = pk(8'hA3, 4, 0, 1, 1, 0, 0);
    if (obs !== exp_v) begin n_err++; $display("FAIL ovf_clear: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_replace_full();
    step(1, 1, 0, 0, 8'h77);
    n_cmp++; exp_v = pk(8'h77, 4, 0, 1, 1, 0, 0);
    if (obs !== exp_v) begin n_err++; $display("FAIL replace_full: got %h want %h", obs, exp_v); end
    step(0, 1, 0, 0, 8'h00);
    n_cmp++; exp_v = pk(8'hA2, 3, 0, 0, 1, 0, 0);
    if (obs !== exp_v) begin n_err++; $display("FAIL pop_after_replace: got %h want %h", obs, exp_v); end
    step(0, 0, 1, 0, 8'h00);
    n_cmp++; exp_v = pk(8'h00, 0, 1, 0, 0, 0, 0);
    if (obs !== exp_v) begin n_err++; $display("FAIL flush_empty: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_underflow_replace();
    step(0, 1, 0, 0, 8'h00);
    n_cmp++; exp_v = pk(8'h00, 0, 1, 0, 0, 0, 1);
    if (obs !== exp_v) begin n_err++; $display("FAIL underflow: got %h want %h", obs, exp_v); end
    step(1, 1, 0, 0, 8'h5A);
    n_cmp++; exp_v = pk(8'h5A, 1, 0, 0, 0, 0, 1);
    if (obs !== exp_v) begin n_err++; $display("FAIL replace_empty: got %h want %h", obs, exp_v); end
    step(0, 0, 1, 1, 8'h00);
    n_cmp++; exp_v = pk(8'h00, 0, 1, 0, 0, 0, 0);
    if (obs !== exp_v) begin n_err++; $display("FAIL flush_clr: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_flush();
    step(1, 0, 0, 0, 8'h01);
    step(1, 0, 0, 0, 8'h02);
    step(1, 0, 0, 0, 8'h03);
    step(1, 0, 1, 0, 8'h99);
    n_cmp++; exp_v = pk(8'h00, 0, 1, 0, 0, 0, 0);
    if (obs !== exp_v) begin n_err++; $display("FAIL flush_push: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_midreset();
    step(1, 0, 0, 0, 8'hC1);
    step(1, 0, 0, 0, 8'hC2);
    n_cmp++; exp_v = pk(8'hC2, 2, 0, 0, 0, 0, 0);
    if (obs !== exp_v) begin n_err++; $display("FAIL pre_reset: got %h want %h", obs, exp_v); end
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_cmp++; exp_v = pk(8'h00, 0, 1, 0, 0, 0, 0);
    if (obs !== exp_v) begin n_err++; $display("FAIL async_reset: got %h want %h", obs, exp_v); end
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'hD0 + 8'(i));
    step(1, 0, 0, 1, 8'hEE);
    n_cmp++; exp_v = pk(8'hD3, 4, 0, 1, 1, 1, 0);
    if (obs !== exp_v) begin n_err++; $display("FAIL set_wins: got %h want %h", obs, exp_v); end
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_cmp++; exp_v = pk(8'h00, 0, 1, 0, 0, 0, 0);
    if (obs !== exp_v) begin n_err++; $display("FAIL async_reset_flags: got %h want %h", obs, exp_v); end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_random();
    bit pu, po, fl, ec;
    for (int i = 0; i < 500; i++) begin
      pu = ($urandom_range(0, 1) == 1);
      po = ($urandom_range(0, 1) == 1);
      fl = ($urandom_range(0, 31) == 0);
      ec = ($urandom_range(0, 15) == 0);
      step(pu, po, fl, ec, 8'($urandom));
      n_cmp++; exp_v = model_vec();
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_replace_full();
    test_underflow_replace();
    test_flush();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
